// File: rtl/ezrisc_pkg.sv
// ezrisc_pkg: definitions shared by the PC / branch sequencing path.
//   br_type_e : branch kinds carried on br_type
//   br_state_e: states of the branch resolution FSM
//   IR field positions and the link register index
package ezrisc_pkg;

   typedef enum logic [1:0] {
      BR_COND = 2'b00,
      BR_JR   = 2'b01,
      BR_JAL  = 2'b10,
      BR_RSVD = 2'b11
   } br_type_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_WAIT_CON = 2'b01,
      ST_APPLY    = 2'b10
   } br_state_e;

   // IR fields: C2 selects the branch condition, OFFSET is the branch displacement
   localparam int IR_C2_HI     = 22;
   localparam int IR_C2_LO     = 19;
   localparam int IR_OFFSET_HI = 18;
   localparam int IR_OFFSET_LO = 0;

   // jal writes its return address to this register
   localparam logic [3:0] LINK_REG = 4'd15;

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control-side inputs and PC/branch-status outputs of the
// PC sequencer.
//   master: drives pc_inc, br_start, br_type, ir, rega_data, con_out
//   slave : drives pc, br_busy, br_done, br_taken, link_we, link_data, inc_drop
interface pc_sequencer_if #(
   parameter int REG_SIZE = 32
);
   logic                pc_inc;
   logic                br_start;
   logic [1:0]          br_type;
   logic [REG_SIZE-1:0] ir;
   logic [REG_SIZE-1:0] rega_data;
   logic                con_out;
   logic [REG_SIZE-1:0] pc;
   logic                br_busy;
   logic                br_done;
   logic                br_taken;
   logic                link_we;
   logic [REG_SIZE-1:0] link_data;
   logic                inc_drop;

   modport master (
      output pc_inc, br_start, br_type, ir, rega_data, con_out,
      input  pc, br_busy, br_done, br_taken, link_we, link_data, inc_drop
   );

   modport slave (
      input  pc_inc, br_start, br_type, ir, rega_data, con_out,
      output pc, br_busy, br_done, br_taken, link_we, link_data, inc_drop
   );
endinterface

// File: rtl/gp_register.sv
// gp_register: general-purpose load-enabled register with synchronous reset.
//   clk, reset : clock, synchronous active-high reset (loads RST_VAL)
//   en, d      : load enable and data
//   q          : register contents
module gp_register #(
   parameter int               WIDTH   = 32,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   always_ff @(posedge clk) begin
      if (reset)   q <= RST_VAL;
      else if (en) q <= d;
   end
endmodule

// File: rtl/pc_target_calc.sv
// pc_target_calc: combinational branch target resolution.
//   pc, offset, rega_data : current PC, branch displacement, R[Ra]
//   br_type, con_out      : branch kind and condition flag
//   next_pc, taken        : redirected PC and whether a redirect happens
module pc_target_calc
   import ezrisc_pkg::*;
#(
   parameter int REG_SIZE = 32,
   parameter int OFFSET_W = 19
) (
   input  logic [REG_SIZE-1:0] pc,
   input  logic [OFFSET_W-1:0] offset,
   input  logic [REG_SIZE-1:0] rega_data,
   input  br_type_e            br_type,
   input  logic                con_out,
   output logic [REG_SIZE-1:0] next_pc,
   output logic                taken
);
   logic [REG_SIZE-1:0] off_sx;

   assign off_sx = {{(REG_SIZE-OFFSET_W){offset[OFFSET_W-1]}}, offset};

   always_comb begin
      next_pc = pc;
      taken   = 1'b0;
      case (br_type)
         BR_COND: begin
            // add wraps modulo 2^REG_SIZE by construction
            next_pc = pc + off_sx;
            taken   = con_out;
         end
         BR_JR, BR_JAL: begin
            next_pc = rega_data;
            taken   = 1'b1;
         end
         default: begin
            next_pc = pc;
            taken   = 1'b0;
         end
      endcase
   end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the program counter; resolves cond branch / jr / jal in a
// fixed three-state sequence (IDLE -> WAIT_CON -> APPLY -> IDLE).
//   clk, reset : clock, synchronous active-high reset
//   bus        : pc_sequencer_if slave (requests in, PC and branch status out)
module pc_sequencer
   import ezrisc_pkg::*;
#(
   parameter int                  REG_SIZE = 32,
   parameter int                  OFFSET_W = 19,
   parameter logic [REG_SIZE-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   pc_sequencer_if.slave   bus
);
   br_state_e           state, state_nxt;
   logic                start_acc, apply;
   br_type_e            lat_type;
   logic [OFFSET_W-1:0] lat_off;
   logic [REG_SIZE-1:0] lat_rega;
   logic [REG_SIZE-1:0] pc_q, pc_d, tgt_pc;
   logic                pc_en, tgt_taken;
   logic                done_q, taken_q, link_we_q, inc_drop_q;
   logic [REG_SIZE-1:0] link_q;
   logic                unused_ir;

   // only the offset field of ir is consumed here
   assign unused_ir = ^bus.ir[REG_SIZE-1:OFFSET_W];

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start_acc = 1'b0;
      apply     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.br_start) begin
               state_nxt = ST_WAIT_CON;
               start_acc = 1'b1;
            end
         end
         // CON is loaded in the br_start cycle; give it one cycle to settle
         ST_WAIT_CON: state_nxt = ST_APPLY;
         ST_APPLY: begin
            state_nxt = ST_IDLE;
            apply     = 1'b1;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // con_out is taken live in APPLY; everything else comes from the latch
   pc_target_calc #(.REG_SIZE(REG_SIZE), .OFFSET_W(OFFSET_W)) u_tgt (
      .pc        (pc_q),
      .offset    (lat_off),
      .rega_data (lat_rega),
      .br_type   (lat_type),
      .con_out   (bus.con_out),
      .next_pc   (tgt_pc),
      .taken     (tgt_taken)
   );

   // br_start wins over pc_inc; increments only happen from a quiet IDLE
   always_comb begin
      pc_en = 1'b0;
      pc_d  = pc_q + REG_SIZE'(1);
      if (apply && tgt_taken) begin
         pc_en = 1'b1;
         pc_d  = tgt_pc;
      end else if (state == ST_IDLE && !bus.br_start && bus.pc_inc) begin
         pc_en = 1'b1;
      end
   end

   gp_register #(.WIDTH(REG_SIZE), .RST_VAL(RESET_PC)) u_pc (
      .clk   (clk),
      .reset (reset),
      .en    (pc_en),
      .d     (pc_d),
      .q     (pc_q)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         lat_type   <= BR_COND;
         lat_off    <= '0;
         lat_rega   <= '0;
         done_q     <= 1'b0;
         taken_q    <= 1'b0;
         link_we_q  <= 1'b0;
         link_q     <= '0;
         inc_drop_q <= 1'b0;
      end else begin
         if (start_acc) begin
            lat_type <= br_type_e'(bus.br_type);
            lat_off  <= bus.ir[OFFSET_W-1:0];
            lat_rega <= bus.rega_data;
         end
         done_q     <= apply;
         taken_q    <= apply && tgt_taken;
         link_we_q  <= apply && (lat_type == BR_JAL);
         // pc_q here is already past any increments issued before the branch
         if (apply && lat_type == BR_JAL) link_q <= pc_q;
         inc_drop_q <= bus.pc_inc && (state != ST_IDLE || bus.br_start);
      end
   end

   assign bus.pc        = pc_q;
   assign bus.br_busy   = (state != ST_IDLE);
   assign bus.br_done   = done_q;
   assign bus.br_taken  = taken_q;
   assign bus.link_we   = link_we_q;
   assign bus.link_data = link_q;
   assign bus.inc_drop  = inc_drop_q;
endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
   localparam int RS = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pc_sequencer_if #(.REG_SIZE(RS)) bus ();

   pc_sequencer #(.REG_SIZE(RS), .OFFSET_W(19), .RESET_PC(32'h0)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;
   logic [31:0] m_pc;
   logic [31:0] m_link;

   // Inputs change and outputs are sampled just after each falling edge.
   task automatic idle_inputs();
      bus.pc_inc = 0; bus.br_start = 0; bus.br_type = 2'b00;
      bus.ir = '0; bus.rega_data = '0; bus.con_out = 0;
   endtask

   task automatic inc_n(input int n);
      for (int i = 0; i < n; i++) begin
         bus.pc_inc = 1;
         @(negedge clk);
      end
      bus.pc_inc = 0;
      m_pc = m_pc + 32'(n);
   endtask

   task automatic test_reset();
      reset = 1; idle_inputs();
      repeat (2) @(negedge clk);
      checks++; if (bus.pc !== 32'h0) begin failures++; $display("FAIL rst_pc got %h exp %h", bus.pc, 32'h0); end
      checks++; if (bus.br_busy !== 1'b0 || bus.br_done !== 1'b0 || bus.br_taken !== 1'b0) begin
         failures++; $display("FAIL rst_status got busy=%b done=%b taken=%b exp 0", bus.br_busy, bus.br_done, bus.br_taken); end
      checks++; if (bus.link_we !== 1'b0 || bus.link_data !== 32'h0 || bus.inc_drop !== 1'b0) begin
         failures++; $display("FAIL rst_link got we=%b data=%h drop=%b exp 0", bus.link_we, bus.link_data, bus.inc_drop); end
      reset = 0; m_pc = 0; m_link = 0;
   endtask

   task automatic test_inc();
      inc_n(3);
      checks++; if (bus.pc !== m_pc) begin failures++; $display("FAIL inc3_pc got %h exp %h", bus.pc, m_pc); end
      bus.pc_inc = 1; reset = 1;
      @(negedge clk);
      checks++; if (bus.pc !== 32'h0) begin failures++; $display("FAIL inc_reset_pc got %h exp %h", bus.pc, 32'h0); end
      reset = 0; bus.pc_inc = 0; m_pc = 0;
   endtask

   // One full branch; noise=1 adds a pc_inc with br_start, plus a second
   // br_start, pc_inc and scrambled operands while busy.
   task automatic test_branch(input logic [1:0] t, input logic [31:0] irv,
                              input logic [31:0] regav, input bit con, input bit noise);
      logic [31:0] exp_pc;
      logic        exp_tk, exp_lwe;
      logic signed [18:0] off;
      off = irv[18:0];
      exp_pc = m_pc; exp_tk = 0; exp_lwe = 0;
      case (t)
         2'd0: if (con) begin exp_pc = m_pc + 32'(off); exp_tk = 1; end
         2'd1: begin exp_pc = regav; exp_tk = 1; end
         2'd2: begin exp_pc = regav; exp_tk = 1; exp_lwe = 1; end
         default: ;
      endcase
      bus.br_start = 1; bus.br_type = t; bus.ir = irv; bus.rega_data = regav;
      bus.con_out = con; bus.pc_inc = noise;
      @(negedge clk);
      checks++; if (bus.br_busy !== 1'b1 || bus.br_done !== 1'b0) begin
         failures++; $display("FAIL br_cyc1 got busy=%b done=%b exp busy=1 done=0", bus.br_busy, bus.br_done); end
      checks++; if (bus.pc !== m_pc) begin failures++; $display("FAIL br_cyc1_pc got %h exp %h", bus.pc, m_pc); end
      checks++; if (bus.inc_drop !== noise) begin failures++; $display("FAIL br_drop1 got %b exp %b", bus.inc_drop, noise); end
      bus.br_start = noise; bus.pc_inc = noise;
      if (noise) begin bus.rega_data = $urandom; bus.ir = $urandom; bus.br_type = 2'($urandom); end
      @(negedge clk);
      checks++; if (bus.br_busy !== 1'b1 || bus.br_done !== 1'b0 || bus.pc !== m_pc) begin
         failures++; $display("FAIL br_cyc2 got busy=%b done=%b pc=%h exp busy=1 done=0 pc=%h", bus.br_busy, bus.br_done, bus.pc, m_pc); end
      checks++; if (bus.inc_drop !== noise) begin failures++; $display("FAIL br_drop2 got %b exp %b", bus.inc_drop, noise); end
      bus.br_start = 0; bus.pc_inc = 0;
      @(negedge clk);
      if (exp_lwe) m_link = m_pc;
      checks++; if (bus.br_done !== 1'b1 || bus.br_busy !== 1'b0) begin
         failures++; $display("FAIL br_done got done=%b busy=%b exp done=1 busy=0", bus.br_done, bus.br_busy); end
      checks++; if (bus.br_taken !== exp_tk) begin failures++; $display("FAIL br_taken got %b exp %b", bus.br_taken, exp_tk); end
      checks++; if (bus.pc !== exp_pc) begin failures++; $display("FAIL br_pc got %h exp %h", bus.pc, exp_pc); end
      checks++; if (bus.link_we !== exp_lwe || bus.link_data !== m_link) begin
         failures++; $display("FAIL br_link got we=%b data=%h exp we=%b data=%h", bus.link_we, bus.link_data, exp_lwe, m_link); end
      checks++; if (bus.inc_drop !== 1'b0) begin failures++; $display("FAIL br_drop3 got %b exp 0", bus.inc_drop); end
      m_pc = exp_pc;
      @(negedge clk);
      checks++; if (bus.br_done !== 1'b0 || bus.link_we !== 1'b0 || bus.br_taken !== 1'b0 || bus.pc !== m_pc) begin
         failures++; $display("FAIL br_after got done=%b we=%b taken=%b pc=%h exp 0/0/0 pc=%h", bus.br_done, bus.link_we, bus.br_taken, bus.pc, m_pc); end
      idle_inputs();
   endtask

   task automatic test_wrap();
      test_branch(2'd1, 32'h0, 32'hFFFF_FFFF, 0, 0);
      inc_n(1);
      checks++; if (bus.pc !== 32'h0) begin failures++; $display("FAIL wrap_inc got %h exp %h", bus.pc, 32'h0); end
      test_branch(2'd1, 32'h0, 32'h2, 0, 0);
      test_branch(2'd0, 32'h0007_FFFD, 32'h0, 1, 0);
      checks++; if (bus.pc !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_neg got %h exp %h", bus.pc, 32'hFFFF_FFFF); end
   endtask

   task automatic test_reset_mid();
      bus.br_start = 1; bus.br_type = 2'd1; bus.rega_data = 32'h1234;
      @(negedge clk);
      bus.br_start = 0;
      checks++; if (bus.br_busy !== 1'b1) begin failures++; $display("FAIL rmid_busy got %b exp 1", bus.br_busy); end
      reset = 1;
      @(negedge clk);
      reset = 0; m_pc = 0; m_link = 0;
      checks++; if (bus.pc !== 32'h0 || bus.br_busy !== 1'b0) begin
         failures++; $display("FAIL rmid_state got pc=%h busy=%b exp pc=0 busy=0", bus.pc, bus.br_busy); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (bus.br_done !== 1'b0 || bus.link_we !== 1'b0 || bus.pc !== 32'h0) begin
            failures++; $display("FAIL rmid_quiet got done=%b we=%b pc=%h exp 0/0/0", bus.br_done, bus.link_we, bus.pc); end
      end
      idle_inputs();
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            inc_n(int'($urandom_range(1, 4)));
            checks++; if (bus.pc !== m_pc) begin failures++; $display("FAIL rnd_inc got %h exp %h", bus.pc, m_pc); end
         end else begin
            test_branch(2'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom));
         end
      end
   endtask

   initial begin
      test_reset();
      test_inc();
      inc_n(16);
      test_branch(2'd0, 32'h0007_FFFE, 32'hDEAD_BEEF, 1, 0);   // 0x10 - 2 = 0x0E
      inc_n(2);
      test_branch(2'd0, 32'h0007_FFFE, 32'hDEAD_BEEF, 0, 0);   // not taken, stays 0x10
      test_branch(2'd3, 32'h0000_0005, 32'h0000_0100, 1, 0);   // reserved
      test_wrap();
      test_branch(2'd1, 32'h0, 32'h0, 0, 0);
      inc_n(32);
      test_branch(2'd2, 32'h0, 32'h0000_0400, 0, 1);           // jal from 0x20 with noise
      test_branch(2'd0, 32'h0000_0010, 32'h0, 1, 1);           // collisions on cond
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
